pwm_fade_ctrl: RTL and testbench
================================

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, width of duty/target (matches pwm_module bit_width).
REQ-002 SHALL have parameter DIV_WIDTH, default 16, width of step-interval divider.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request a fade; sampled on clk edge.
REQ-006 SHALL have port abort  input  1  cancel an active fade; sampled on clk edge.
REQ-007 SHALL have port target  input  BIT_WIDTH  final duty value; captured on accepted start.
REQ-008 SHALL have port step_div  input  DIV_WIDTH  D; duty steps once every D+1 cycles; captured on accepted start.
REQ-009 SHALL have port duty  output  BIT_WIDTH  registered duty value driving pwm_module duty.
REQ-010 SHALL have port busy  output  1  high while in RAMP.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, RAMP, DONE; all outputs registered.
REQ-013 SHALL, in IDLE with start=1 and abort=0, capture target->tgt_q, step_div->div_q, clear step counter cnt to 0.
REQ-014 SHALL, on accepted start with target!=duty, enter RAMP; with target==duty, enter DONE directly (busy never asserts).
REQ-015 SHALL, each edge in RAMP with abort=0: if cnt==div_q, step duty by +1 (duty<tgt_q) or -1 (duty>tgt_q) and set cnt=0; else cnt=cnt+1.
REQ-016 SHALL, on the edge that writes duty==tgt_q, transition RAMP->DONE on that same edge.
REQ-017 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-018 SHALL give first duty change D+1 edges after the start-capture edge; total ramp |target-duty0|*(D+1) edges.
REQ-019 SHALL never wrap duty: steps are +-1 toward tgt_q only; duty stays within [min(duty0,target), max(duty0,target)].
REQ-020 SHALL ignore start in RAMP and DONE (no re-capture, no effect on tgt_q/div_q/cnt).
REQ-021 SHALL, on abort=1 in RAMP, go to IDLE next edge, freeze duty at current value, busy=0, no done pulse.
REQ-022 SHALL give abort priority over start in the same cycle; abort in IDLE or DONE has no effect.
REQ-023 SHALL hold duty constant in IDLE and DONE.
REQ-024 SHALL treat D=0 as one step per clock.

Reset
REQ-025 SHALL, while rst_n=0 (asynchronously, no clock needed), force state=IDLE, duty=0, busy=0, done=0, cnt=0, tgt_q=0, div_q=0.
REQ-026 SHALL, on reset asserted mid-RAMP, abandon the fade with no done pulse; first start after release is accepted normally.

Verification
REQ-027 SHALL check: rst_n=0 with clk stopped -> duty=0, busy=0, done=0 immediately.
REQ-028 SHALL check: BW=8, D=0, duty=0, start target=5 -> duty 1,2,3,4,5 on 5 consecutive edges; busy high 5 cycles; done high one cycle from the edge writing 5.
REQ-029 SHALL check: D=3, duty=5, start target=2 -> duty changes every 4 edges (5->4->3->2), 12 edges total, then single done pulse.
REQ-030 SHALL check: duty=7, start target=7 -> busy stays 0, done high for one cycle after capture edge, duty stays 7.
REQ-031 SHALL check: D=0 ramp 0->200, abort at duty=50 with start also high -> duty holds 50, busy=0 next edge, no done; start pulses during the earlier ramp ignored.
REQ-032 SHALL check: rst_n asserted mid-ramp at duty=30 -> duty=0 asynchronously, no done; after release, start target=3 D=1 -> duty 1,2,3 every 2 edges, then done.

Source files
------------

// File: rtl/pwm_fade_ctrl_if.sv
// pwm_fade_ctrl_if
// Control bundle for pwm_fade_ctrl.
//   start    : request a fade (master -> slave)
//   abort    : cancel an active fade (master -> slave)
//   target   : final duty value, captured on an accepted start
//   step_div : D, duty steps once every D+1 cycles, captured on an accepted start
//   duty     : registered duty value (slave -> master)
//   busy     : high while ramping (slave -> master)
//   done     : one-cycle completion pulse (slave -> master)
interface pwm_fade_ctrl_if #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned DIV_WIDTH = 16
);
  logic                 start;
  logic                 abort;
  logic [BIT_WIDTH-1:0] target;
  logic [DIV_WIDTH-1:0] step_div;
  logic [BIT_WIDTH-1:0] duty;
  logic                 busy;
  logic                 done;

  modport master (
    output start, abort, target, step_div,
    input  duty, busy, done
  );

  modport slave (
    input  start, abort, target, step_div,
    output duty, busy, done
  );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl
// Ramps a PWM duty value by +-1 toward a captured target, one step every
// step_div+1 clocks, then emits a one-cycle done pulse.
// Ports:
//   clk   : single clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pwm_fade_ctrl_if.slave (start, abort, target, step_div in;
//           duty, busy, done out; all outputs registered)
module pwm_fade_ctrl #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_fade_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RAMP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [BIT_WIDTH-1:0] DUTY_ONE = BIT_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE  = DIV_WIDTH'(1);

  logic [1:0]           state;
  logic [BIT_WIDTH-1:0] duty_q;
  logic [BIT_WIDTH-1:0] duty_next;
  logic [BIT_WIDTH-1:0] tgt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt;
  logic                 busy_q;
  logic                 done_q;

  // Only ever moves one count toward tgt_q, so duty can never wrap.
  always_comb begin
    duty_next = duty_q;
    if (duty_q < tgt_q) begin
      duty_next = duty_q + DUTY_ONE;
    end else if (duty_q > tgt_q) begin
      duty_next = duty_q - DUTY_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      duty_q <= '0;
      tgt_q  <= '0;
      div_q  <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // abort outranks start in the same cycle
          if (bus.start && !bus.abort) begin
            tgt_q <= bus.target;
            div_q <= bus.step_div;
            cnt   <= '0;
            if (bus.target != duty_q) begin
              state  <= RAMP;
              busy_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (cnt == div_q) begin
            cnt    <= '0;
            duty_q <= duty_next;
            // Finish on the very edge that lands on the target.
            if (duty_next == tgt_q) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.duty = duty_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl
// Self-checking bench for pwm_fade_ctrl. Expected outputs come from a
// closed-form model: k edges after the capture edge, duty has moved
// min(k/(D+1), |target-duty0|) counts toward target; busy holds until the
// total ramp time |target-duty0|*(D+1) and done fires exactly at it.
module tb_pwm_fade_ctrl;

  localparam int unsigned BW = 8;
  localparam int unsigned DW = 16;

  logic clk;
  logic clk_en;
  logic rst_n;

  int checks;
  int errors;
  int model_duty;

  pwm_fade_ctrl_if #(.BIT_WIDTH(BW), .DIV_WIDTH(DW)) bus ();

  pwm_fade_ctrl #(.BIT_WIDTH(BW), .DIV_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 if (clk_en) clk = ~clk;

  // Runs one fade from model_duty to tgt with divider d. With noise set,
  // random start pulses are applied while the DUT is ramping or in DONE, and
  // a random abort while in DONE; none of these may change anything.
  // abort_at >= 0 raises abort (together with start) after the k=abort_at
  // sample, so duty must freeze at its value from that point.
  task automatic do_fade(input int tgt, input int d, input bit noise, input int abort_at);
    int n, sgn, total, last, kk, steps;
    bit after_abort, exp_busy, exp_done;
    logic [BW-1:0] exp_duty;
    n     = (tgt > model_duty) ? tgt - model_duty : model_duty - tgt;
    sgn   = (tgt > model_duty) ? 1 : -1;
    total = n * (d + 1);
    last  = (abort_at >= 0) ? abort_at + 4 : total + 1;
    bus.start    = 1'b1;
    bus.abort    = 1'b0;
    bus.target   = BW'(tgt);
    bus.step_div = DW'(d);
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      #1;
      after_abort = (abort_at >= 0) && (k > abort_at);
      kk       = after_abort ? abort_at : k;
      steps    = kk / (d + 1);
      if (steps > n) steps = n;
      exp_duty = BW'(model_duty + sgn * steps);
      exp_busy = !after_abort && (k < total);
      exp_done = !after_abort && (k == total);
      checks++;
      if (bus.duty !== exp_duty) begin
        errors++;
        $display("FAIL fade_duty tgt=%0d d=%0d k=%0d: got %0d expected %0d", tgt, d, k, bus.duty, exp_duty);
      end
      checks++;
      if (bus.busy !== exp_busy) begin
        errors++;
        $display("FAIL fade_busy tgt=%0d d=%0d k=%0d: got %b expected %b", tgt, d, k, bus.busy, exp_busy);
      end
      checks++;
      if (bus.done !== exp_done) begin
        errors++;
        $display("FAIL fade_done tgt=%0d d=%0d k=%0d: got %b expected %b", tgt, d, k, bus.done, exp_done);
      end
      if (abort_at >= 0 && k == abort_at) begin
        bus.start = 1'b1;
        bus.abort = 1'b1;
      end else if (abort_at >= 0 && k > abort_at) begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
      end else begin
        bus.start = noise && (k <= total) ? 1'($urandom) : 1'b0;
        bus.abort = noise && (k == total) ? 1'($urandom) : 1'b0;
      end
      bus.target   = BW'($urandom);
      bus.step_div = DW'($urandom_range(0, 3));
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (abort_at >= 0) begin
      steps = abort_at / (d + 1);
      if (steps > n) steps = n;
      model_duty = model_duty + sgn * steps;
    end else begin
      model_duty = tgt;
    end
  endtask

  task automatic test_reset();
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.target   = '0;
    bus.step_div = '0;
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.duty !== '0) begin
      errors++;
      $display("FAIL reset_duty: got %0d expected 0", bus.duty);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_duty = 0;
  endtask

  task automatic test_basic_up();
    do_fade(5, 0, 1'b0, -1);
  endtask

  task automatic test_down_div();
    do_fade(2, 3, 1'b1, -1);
  endtask

  task automatic test_equal_target();
    do_fade(7, 2, 1'b0, -1);
    do_fade(7, 0, 1'b0, -1);
  endtask

  task automatic test_abort_ramp();
    do_fade(0, 0, 1'b0, -1);
    do_fade(200, 0, 1'b1, 50);
  endtask

  task automatic test_abort_idle();
    logic [BW-1:0] exp_duty;
    exp_duty     = BW'(model_duty);
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    bus.target   = BW'(model_duty + 9);
    bus.step_div = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus.start = 1'b0;
      checks++;
      if (bus.duty !== exp_duty) begin
        errors++;
        $display("FAIL abort_idle_duty k=%0d: got %0d expected %0d", k, bus.duty, exp_duty);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle_flags k=%0d: got busy=%b done=%b expected 0 0", k, bus.busy, bus.done);
      end
    end
    bus.abort = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_fade(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b1, -1);
    end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] exp_duty;
    do_fade(50, 0, 1'b0, -1);
    bus.start    = 1'b1;
    bus.target   = '0;
    bus.step_div = '0;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      exp_duty  = BW'(50 - k);
      checks++;
      if (bus.duty !== exp_duty || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL midreset_ramp k=%0d: got duty=%0d busy=%b expected %0d 1", k, bus.duty, bus.busy, exp_duty);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.duty !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: got duty=%0d busy=%b done=%b expected 0 0 0", bus.duty, bus.busy, bus.done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.duty !== '0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL midreset_after k=%0d: got duty=%0d done=%b expected 0 0", k, bus.duty, bus.done);
      end
    end
    model_duty = 0;
    do_fade(3, 1, 1'b0, -1);
  endtask

  initial begin
    clk        = 1'b0;
    clk_en     = 1'b0;
    checks     = 0;
    errors     = 0;
    model_duty = 0;
    test_reset();
    test_basic_up();
    test_down_div();
    test_equal_target();
    test_abort_ramp();
    test_abort_idle();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
